// File: rtl/spi_btn_led_regs_if.sv
// SPI link from the ESP32 (master) to the FPGA register slave, mode 0.
// The slave drives MISO plus an enable that the top level uses to tristate the pin.
interface spi_btn_led_regs_if;
    logic spi_csn;
    logic spi_sclk;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (
        output spi_csn,
        output spi_sclk,
        output spi_mosi,
        input  spi_miso,
        input  spi_miso_oe
    );

    modport slave (
        input  spi_csn,
        input  spi_sclk,
        input  spi_mosi,
        output spi_miso,
        output spi_miso_oe
    );
endinterface

// File: rtl/spi_btn_led_regs.sv
// Oversampled SPI register slave: LED register, debounced buttons and a read-to-clear
// button-change latch with an interrupt line, all clocked from clk_25mhz.
module spi_btn_led_regs #(
    parameter int DEB_BITS = 16,
    parameter int NBTN     = 7
) (
    input  logic              clk_25mhz,
    input  logic              rstn,
    input  logic [NBTN-1:0]   btn,
    spi_btn_led_regs_if.slave spi,
    output logic [7:0]        led,
    output logic [NBTN-1:0]   btn_db,
    output logic              irq
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } state_t;

    localparam logic [7:0]          ADDR_LED = 8'h00;
    localparam logic [7:0]          ADDR_BTN = 8'h01;
    localparam logic [7:0]          ADDR_CHG = 8'h02;
    localparam logic [7:0]          ADDR_ONE = 8'h01;
    localparam logic [2:0]          BIT_ONE  = 3'd1;
    localparam logic [2:0]          BIT_LAST = 3'd7;
    localparam logic [DEB_BITS-1:0] DEB_ONE  = 1;
    localparam logic [DEB_BITS-1:0] DEB_ALL  = '1;

    logic [NBTN-1:0]     r_btnMeta;
    logic [NBTN-1:0]     r_btnSync;
    logic                r_csnMeta;
    logic                r_csnSync;
    logic                r_csnDly;
    logic                r_sclkMeta;
    logic                r_sclkSync;
    logic                r_sclkDly;
    logic                r_mosiMeta;
    logic                r_mosiSync;

    logic [DEB_BITS-1:0] r_debCnt [NBTN];
    logic [NBTN-1:0]     r_btnDb;
    logic [NBTN-1:0]     r_chg;
    logic                r_irq;

    state_t              r_state;
    logic [2:0]          r_bitCnt;
    logic [6:0]          r_rx;
    logic [7:0]          r_tx;
    logic                r_oe;
    logic [7:0]          r_addr;
    logic [7:0]          r_led;

    logic                w_csnFall;
    logic                w_csnRise;
    logic                w_sclkRise;
    logic                w_sclkFall;
    logic [DEB_BITS-1:0] w_debCntInc [NBTN];
    logic [NBTN-1:0]     w_debEvent;
    state_t              w_stateNext;
    logic                w_byteDone;
    logic                w_addrLoad;
    logic                w_dataWrite;
    logic [7:0]          w_rxNext;
    logic [7:0]          w_addrNext;
    logic [7:0]          w_ledNext;
    logic [7:0]          w_btnByte;
    logic [7:0]          w_chgByte;
    logic [7:0]          w_rdData;
    logic                w_chgClr;
    logic [NBTN-1:0]     w_chgNext;

    // csn/sclk synchronisers reset to their idle levels so reset release never fakes an edge
    always_ff @(posedge clk_25mhz or negedge rstn) begin
        if (!rstn) begin
            r_btnMeta  <= '0;
            r_btnSync  <= '0;
            r_csnMeta  <= 1'b1;
            r_csnSync  <= 1'b1;
            r_csnDly   <= 1'b1;
            r_sclkMeta <= 1'b0;
            r_sclkSync <= 1'b0;
            r_sclkDly  <= 1'b0;
            r_mosiMeta <= 1'b0;
            r_mosiSync <= 1'b0;
        end else begin
            r_btnMeta  <= btn;
            r_btnSync  <= r_btnMeta;
            r_csnMeta  <= spi.spi_csn;
            r_csnSync  <= r_csnMeta;
            r_csnDly   <= r_csnSync;
            r_sclkMeta <= spi.spi_sclk;
            r_sclkSync <= r_sclkMeta;
            r_sclkDly  <= r_sclkSync;
            r_mosiMeta <= spi.spi_mosi;
            r_mosiSync <= r_mosiMeta;
        end
    end

    assign w_csnFall  =  r_csnDly  & ~r_csnSync;
    assign w_csnRise  = ~r_csnDly  &  r_csnSync;
    assign w_sclkRise = ~r_sclkDly &  r_sclkSync;
    assign w_sclkFall =  r_sclkDly & ~r_sclkSync;

    // The accept fires on the clock where the counter would reach all-ones, so the
    // synced input has differed from btn_db for exactly 2^DEB_BITS-1 clocks
    always_comb begin
        w_debEvent = '0;
        for (int i = 0; i < NBTN; i++) begin
            w_debCntInc[i] = r_debCnt[i] + DEB_ONE;
            w_debEvent[i]  = (r_btnSync[i] != r_btnDb[i]) && (w_debCntInc[i] == DEB_ALL);
        end
    end

    always_ff @(posedge clk_25mhz or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NBTN; i++) begin
                r_debCnt[i] <= '0;
            end
            r_btnDb <= '0;
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                if (r_btnSync[i] == r_btnDb[i]) begin
                    r_debCnt[i] <= '0;
                end else if (w_debEvent[i]) begin
                    r_debCnt[i] <= '0;
                    r_btnDb[i]  <= r_btnSync[i];
                end else begin
                    r_debCnt[i] <= w_debCntInc[i];
                end
            end
        end
    end

    always_ff @(posedge clk_25mhz or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_byteDone  = 1'b0;
        w_addrLoad  = 1'b0;
        w_dataWrite = 1'b0;
        if (w_csnFall) begin
            w_stateNext = ST_ADDR;
        end else if (w_csnRise) begin
            w_stateNext = ST_IDLE;
        end else if ((r_state != ST_IDLE) && w_sclkRise && (r_bitCnt == BIT_LAST)) begin
            w_byteDone = 1'b1;
            if (r_state == ST_ADDR) begin
                w_stateNext = ST_DATA;
                w_addrLoad  = 1'b1;
            end else begin
                w_dataWrite = 1'b1;
            end
        end
    end

    assign w_rxNext = {r_rx, r_mosiSync};

    always_comb begin
        w_addrNext = r_addr;
        if (w_addrLoad) begin
            w_addrNext = w_rxNext;
        end else if (w_dataWrite) begin
            w_addrNext = r_addr + ADDR_ONE;
        end
    end

    assign w_ledNext = (w_dataWrite && (r_addr == ADDR_LED)) ? w_rxNext : r_led;

    always_comb begin
        w_btnByte             = '0;
        w_btnByte[NBTN-1:0]   = r_btnDb;
        w_chgByte             = '0;
        w_chgByte[NBTN-1:0]   = r_chg;
        w_rdData              = 8'h00;
        case (w_addrNext)
            ADDR_LED: w_rdData = w_ledNext;
            ADDR_BTN: w_rdData = w_btnByte;
            ADDR_CHG: w_rdData = w_chgByte;
            default:  w_rdData = 8'h00;
        endcase
    end

    // Clearing drops exactly the bits that went into tx; a same-cycle debounce event survives
    assign w_chgClr  = w_byteDone && (w_addrNext == ADDR_CHG);
    assign w_chgNext = w_chgClr ? w_debEvent : (r_chg | w_debEvent);

    always_ff @(posedge clk_25mhz or negedge rstn) begin
        if (!rstn) begin
            r_chg  <= '0;
            r_irq  <= 1'b0;
            r_addr <= 8'h00;
            r_led  <= 8'h00;
        end else begin
            r_chg  <= w_chgNext;
            r_irq  <= |r_chg;
            r_addr <= w_addrNext;
            r_led  <= w_ledNext;
        end
    end

    // The falling edge right after a byte boundary (bit count wrapped to 0) must not shift,
    // otherwise the MSB of the freshly loaded byte would be lost before the master samples it
    always_ff @(posedge clk_25mhz or negedge rstn) begin
        if (!rstn) begin
            r_bitCnt <= 3'd0;
            r_rx     <= 7'd0;
            r_tx     <= 8'h00;
            r_oe     <= 1'b0;
        end else if (w_csnFall) begin
            r_bitCnt <= 3'd0;
            r_tx     <= w_btnByte;
            r_oe     <= 1'b1;
        end else if (w_csnRise) begin
            r_bitCnt <= 3'd0;
            r_oe     <= 1'b0;
        end else if (r_state != ST_IDLE) begin
            if (w_sclkRise) begin
                r_rx     <= w_rxNext[6:0];
                r_bitCnt <= r_bitCnt + BIT_ONE;
                if (w_byteDone) begin
                    r_tx <= w_rdData;
                end
            end else if (w_sclkFall && (r_bitCnt != 3'd0)) begin
                r_tx <= {r_tx[6:0], 1'b0};
            end
        end
    end

    assign spi.spi_miso    = r_tx[7];
    assign spi.spi_miso_oe = r_oe;
    assign led             = r_led;
    assign btn_db          = r_btnDb;
    assign irq             = r_irq;

endmodule

// File: tb/tb_spi_btn_led_regs.sv
// Bench for spi_btn_led_regs: table of SPI frames whose MISO bytes go through a scoreboard
// queue, plus hand-written debounce, clear-race, abort and mid-frame reset sequences.
module tb_spi_btn_led_regs;
    localparam int DEB_BITS = 4;
    localparam int NBTN     = 7;
    localparam int HALF     = 5;
    localparam int NVEC     = 8;

    logic            clk = 1'b0;
    logic            rstn;
    logic [NBTN-1:0] btn;
    logic [7:0]      led;
    logic [NBTN-1:0] btnDb;
    logic            irq;

    spi_btn_led_regs_if spiBus();

    spi_btn_led_regs #(
        .DEB_BITS (DEB_BITS),
        .NBTN     (NBTN)
    ) dut (
        .clk_25mhz (clk),
        .rstn      (rstn),
        .btn       (btn),
        .spi       (spiBus),
        .led       (led),
        .btn_db    (btnDb),
        .irq       (irq)
    );

    always #20 clk = ~clk;

    typedef struct packed {
        logic [2:0]      nBytes;
        logic [3:0][7:0] mosi;
        logic [3:0][7:0] miso;
        logic [7:0]      expLed;
        logic            expIrq;
    } frameVec_t;

    frameVec_t  vecs [NVEC];
    logic [7:0] expQ [$];
    int         total = 0;
    int         bad   = 0;

    function automatic frameVec_t mkVec(input int n,
                                        input logic [7:0] m0, input logic [7:0] m1,
                                        input logic [7:0] m2, input logic [7:0] m3,
                                        input logic [7:0] e0, input logic [7:0] e1,
                                        input logic [7:0] e2, input logic [7:0] e3,
                                        input logic [7:0] l, input logic i);
        frameVec_t v;
        v.nBytes = 3'(n);
        v.mosi   = {m3, m2, m1, m0};
        v.miso   = {e3, e2, e1, e0};
        v.expLed = l;
        v.expIrq = i;
        return v;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string what, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", what, act, exp);
        end
    endtask

    task automatic checkMiso(input string what, input logic [7:0] got);
        logic [7:0] exp;
        if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s: got 0x%02h but no byte was expected", what, got);
        end else begin
            exp = expQ.pop_front();
            checkOutput(what, 32'(got), 32'(exp));
        end
    endtask

    // MISO is sampled just before each rising sclk, as the ESP32 would
    task automatic transferByte(input logic [7:0] mosiByte, input int nBits, output logic [7:0] misoByte);
        misoByte = 8'h00;
        for (int i = 7; i > 7 - nBits; i--) begin
            spiBus.spi_mosi = mosiByte[i];
            cycles(HALF);
            misoByte[i] = spiBus.spi_miso;
            spiBus.spi_sclk = 1'b1;
            cycles(HALF);
            spiBus.spi_sclk = 1'b0;
        end
    endtask

    task automatic applyStimulus(input int idx);
        frameVec_t  v;
        logic [7:0] got;
        v = vecs[idx];
        for (int b = 0; b < int'(v.nBytes); b++) begin
            expQ.push_back(v.miso[b]);
        end
        spiBus.spi_csn = 1'b0;
        for (int b = 0; b < int'(v.nBytes); b++) begin
            transferByte(v.mosi[b], 8, got);
            checkMiso($sformatf("vec%0d miso byte%0d", idx, b), got);
        end
        cycles(HALF);
        spiBus.spi_csn = 1'b1;
        cycles(HALF);
        checkOutput($sformatf("vec%0d led", idx), 32'(led), 32'(v.expLed));
        checkOutput($sformatf("vec%0d irq", idx), 32'(irq), 32'(v.expIrq));
        checkOutput($sformatf("vec%0d miso_oe", idx), 32'(spiBus.spi_miso_oe), 32'h0);
    endtask

    initial begin
        #1200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] got;
        int         hit;

        vecs[0] = mkVec(2, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'hA5, 1'b1);
        vecs[1] = mkVec(3, 8'h02, 8'h00, 8'h00, 8'h00, 8'h08, 8'h08, 8'h00, 8'h00, 8'hA5, 1'b0);
        vecs[2] = mkVec(4, 8'h00, 8'h3C, 8'hFF, 8'hFF, 8'h08, 8'hA5, 8'h08, 8'h00, 8'h3C, 1'b0);
        vecs[3] = mkVec(2, 8'h05, 8'h77, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h3C, 1'b0);
        vecs[4] = mkVec(3, 8'hFF, 8'h12, 8'h99, 8'h00, 8'h08, 8'h00, 8'h3C, 8'h00, 8'h99, 1'b0);
        vecs[5] = mkVec(2, 8'h01, 8'h55, 8'h00, 8'h00, 8'h08, 8'h08, 8'h00, 8'h00, 8'h99, 1'b0);
        vecs[6] = mkVec(2, 8'h02, 8'h00, 8'h00, 8'h00, 8'h02, 8'h02, 8'h00, 8'h00, 8'h99, 1'b0);
        vecs[7] = mkVec(2, 8'h00, 8'h42, 8'h00, 8'h00, 8'h02, 8'h99, 8'h00, 8'h00, 8'h42, 1'b0);

        rstn            = 1'b0;
        btn             = '0;
        spiBus.spi_csn  = 1'b1;
        spiBus.spi_sclk = 1'b0;
        spiBus.spi_mosi = 1'b0;
        cycles(3);
        checkOutput("reset led", 32'(led), 32'h00);
        checkOutput("reset btn_db", 32'(btnDb), 32'h00);
        checkOutput("reset irq", 32'(irq), 32'h0);
        checkOutput("reset miso", 32'(spiBus.spi_miso), 32'h0);
        checkOutput("reset miso_oe", 32'(spiBus.spi_miso_oe), 32'h0);
        rstn = 1'b1;
        cycles(100);
        checkOutput("idle irq", 32'(irq), 32'h0);
        checkOutput("idle led", 32'(led), 32'h00);

        btn[3] = 1'b1;
        hit = -1;
        for (int c = 1; c <= 40 && hit < 0; c++) begin
            @(posedge clk);
            #1;
            if (btnDb[3] === 1'b1) hit = c;
        end
        checkOutput("debounce latency", 32'(hit), 32'd17);
        checkOutput("irq lags btn_db", 32'(irq), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("irq after step", 32'(irq), 32'h1);
        @(negedge clk);

        btn[5] = 1'b1;
        cycles(10);
        btn[5] = 1'b0;
        cycles(30);
        checkOutput("glitch ignored", 32'(btnDb), 32'h08);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(i);
        end

        btn[3] = 1'b0;
        cycles(25);
        checkOutput("btn3 release", 32'(btnDb), 32'h00);
        checkOutput("btn3 release irq", 32'(irq), 32'h1);

        // btn[1] steps 14 cycles before the 8th rising sclk so its debounce accept
        // lands on the same clock as the chg register load
        expQ.push_back(8'h00);
        expQ.push_back(8'h08);
        spiBus.spi_csn = 1'b0;
        transferByte(8'h02, 7, got);
        spiBus.spi_mosi = 1'b0;
        btn[1] = 1'b1;
        cycles(14);
        got[0] = spiBus.spi_miso;
        spiBus.spi_sclk = 1'b1;
        cycles(HALF);
        spiBus.spi_sclk = 1'b0;
        checkMiso("race status byte", got);
        transferByte(8'h00, 8, got);
        checkMiso("race chg byte", got);
        cycles(HALF);
        spiBus.spi_csn = 1'b1;
        cycles(HALF);
        checkOutput("race btn_db", 32'(btnDb), 32'h02);
        checkOutput("race irq kept", 32'(irq), 32'h1);
        applyStimulus(6);

        expQ.push_back(8'h02);
        spiBus.spi_csn = 1'b0;
        transferByte(8'h00, 8, got);
        checkMiso("abort status byte", got);
        transferByte(8'h5A, 5, got);
        checkOutput("abort oe in frame", 32'(spiBus.spi_miso_oe), 32'h1);
        cycles(HALF);
        spiBus.spi_csn = 1'b1;
        cycles(3);
        checkOutput("abort oe released", 32'(spiBus.spi_miso_oe), 32'h0);
        checkOutput("abort led kept", 32'(led), 32'h99);
        cycles(HALF);
        applyStimulus(7);

        expQ.push_back(8'h02);
        spiBus.spi_csn = 1'b0;
        transferByte(8'h00, 8, got);
        checkMiso("midreset status byte", got);
        transferByte(8'h11, 3, got);
        rstn = 1'b0;
        #1;
        checkOutput("midreset oe", 32'(spiBus.spi_miso_oe), 32'h0);
        checkOutput("midreset led", 32'(led), 32'h00);
        checkOutput("midreset btn_db", 32'(btnDb), 32'h00);
        checkOutput("midreset miso", 32'(spiBus.spi_miso), 32'h0);
        spiBus.spi_csn  = 1'b1;
        spiBus.spi_sclk = 1'b0;
        cycles(2);
        rstn = 1'b1;
        cycles(5);
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
